// File: rtl/pipe_pkg.sv
// Shared encodings and constants for the generic pipeline stage buffer.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int unsigned STALL_CNT_W = 16;

  // Replicated to CTRL_W to form the default bubble pattern.
  localparam logic BUBBLE_BIT = 1'b0;

endpackage

// File: rtl/pipe_entry.sv
// One {valid, ctrl, data} slot. clr_i invalidates and bubbles ctrl but keeps data.
module pipe_entry #(
  parameter int unsigned          CTRL_W   = 32,
  parameter int unsigned          DATA_W   = 128,
  parameter logic [CTRL_W-1:0]    CTRL_RST = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              drop_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_RST;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_RST;
    end else if (en_i) begin
      if (load_i) begin
        valid_q <= 1'b1;
        ctrl_q  <= ctrl_i;
        data_q  <= data_i;
      end else if (drop_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic valid/ready pipeline stage with optional 2-entry skid buffer, flush,
// control-only kill and a saturating stall counter.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned       CTRL_W   = 32,
  parameter int unsigned       DATA_W   = 128,
  parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{BUBBLE_BIT}},
  parameter int unsigned       SKID     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   kill_ctrl,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic              accept, issue;
  logic              m_load, m_drop, m_valid;
  logic [CTRL_W-1:0] m_ctrl_d, m_ctrl, in_ctrl_k;
  logic [DATA_W-1:0] m_data_d, m_data;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  assign in_ctrl_k = kill_ctrl ? CTRL_RST : in_ctrl;
  assign out_valid = en & m_valid;
  assign issue     = out_valid & out_ready;
  assign accept    = in_valid & in_ready;
  assign out_ctrl  = m_ctrl;
  assign out_data  = m_data;

  pipe_entry #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .CTRL_RST (CTRL_RST)
  ) u_m (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .clr_i   (flush),
    .load_i  (m_load),
    .drop_i  (m_drop),
    .ctrl_i  (m_ctrl_d),
    .data_i  (m_data_d),
    .valid_o (m_valid),
    .ctrl_o  (m_ctrl),
    .data_o  (m_data)
  );

  if (SKID != 0) begin : g_skid
    state_e            state_q, state_d;
    logic              ready_q, s_load, s_drop, m_from_s, s_valid;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;

    pipe_entry #(
      .CTRL_W   (CTRL_W),
      .DATA_W   (DATA_W),
      .CTRL_RST (CTRL_RST)
    ) u_s (
      .clk_i   (clk),
      .rst_i   (rst),
      .en_i    (en),
      .clr_i   (flush),
      .load_i  (s_load),
      .drop_i  (s_drop),
      .ctrl_i  (in_ctrl_k),
      .data_i  (in_data),
      .valid_o (s_valid),
      .ctrl_o  (s_ctrl),
      .data_o  (s_data)
    );

    always_comb begin
      state_d  = state_q;
      m_load   = 1'b0;
      m_drop   = 1'b0;
      m_from_s = 1'b0;
      s_load   = 1'b0;
      s_drop   = 1'b0;
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            m_load  = 1'b1;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && issue) begin
            m_load = 1'b1;
          end else if (accept) begin
            s_load  = 1'b1;
            state_d = ST_FULL;
          end else if (issue) begin
            m_drop  = 1'b1;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (issue && s_valid) begin
            m_load   = 1'b1;
            m_from_s = 1'b1;
            s_drop   = 1'b1;
            state_d  = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    // Ready is precomputed from the next state so a FULL buffer is never overrun.
    always_ff @(posedge clk) begin
      if (rst || flush) begin
        state_q <= ST_EMPTY;
        ready_q <= 1'b1;
      end else if (en) begin
        state_q <= state_d;
        ready_q <= (state_d != ST_FULL);
      end
    end

    assign m_ctrl_d  = m_from_s ? s_ctrl : in_ctrl_k;
    assign m_data_d  = m_from_s ? s_data : in_data;
    assign in_ready  = ~rst & en & ready_q;
    assign occupancy = state_q;
  end else begin : g_single
    // Load wins over drop in the entry, giving full throughput on accept & issue.
    assign m_load    = accept;
    assign m_drop    = issue;
    assign m_ctrl_d  = in_ctrl_k;
    assign m_data_d  = in_data;
    assign in_ready  = ~rst & en & (~m_valid | out_ready);
    assign occupancy = {1'b0, m_valid};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench: drives a SKID=1 and a SKID=0 instance with the same stimulus.
module tb_pipe_stage_buf;

  localparam int unsigned   CW  = 8;
  localparam int unsigned   DW  = 32;
  localparam logic [CW-1:0] BUB = 8'hC3;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, flush = 1'b0, kill_ctrl = 1'b0, in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic [1:0]    in_ready_w, out_valid_w;
  logic [CW-1:0] out_ctrl_w [2];
  logic [DW-1:0] out_data_w [2];
  logic [1:0]    occ_w [2];
  logic [15:0]   stall_w [2];

  always #5 clk = ~clk;

  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .CTRL_RST(BUB), .SKID(1)) u_dut_skid (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .kill_ctrl(kill_ctrl),
    .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_ctrl(out_ctrl_w[0]),
    .out_data(out_data_w[0]), .occupancy(occ_w[0]), .stall_cnt(stall_w[0])
  );

  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .CTRL_RST(BUB), .SKID(0)) u_dut_single (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .kill_ctrl(kill_ctrl),
    .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_ctrl(out_ctrl_w[1]),
    .out_data(out_data_w[1]), .occupancy(occ_w[1]), .stall_cnt(stall_w[1])
  );

  // Reference model: per DUT, a FIFO of accepted beats (tail owned by the driver,
  // head owned by the monitor), plus expected counter and post-clear flags.
  logic [CW-1:0] sb_ctrl [2][256];
  logic [DW-1:0] sb_data [2][256];
  logic [7:0]    head [2] = '{8'd0, 8'd0};
  logic [7:0]    tail [2] = '{8'd0, 8'd0};
  logic          exp_ready [2] = '{1'b0, 1'b0};
  logic [15:0]   exp_stall [2] = '{16'd0, 16'd0};
  logic          bubble [2] = '{1'b1, 1'b1};
  logic          zdata [2] = '{1'b1, 1'b1};
  logic          armed = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, idx, act, exp,
               $time);
    end
  endtask

  // Monitor: compares the presented outputs with the model, then retires issued beats.
  logic [7:0] sz;
  logic       ev, er;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      sz = tail[i] - head[i];
      if (sz != 8'd0) begin
        bubble[i] = 1'b0;
        zdata[i]  = 1'b0;
      end
      ev = en && (sz != 8'd0);
      if (i == 0) er = en && !rst && (sz < 8'd2);
      else        er = en && !rst && ((sz == 8'd0) || out_ready);
      exp_ready[i] = er;
      if (armed) begin
        chk("in_ready", i, 64'(in_ready_w[i]), 64'(er));
        chk("out_valid", i, 64'(out_valid_w[i]), 64'(ev));
        chk("occupancy", i, 64'(occ_w[i]), 64'(sz));
        chk("stall_cnt", i, 64'(stall_w[i]), 64'(exp_stall[i]));
        if (ev) begin
          chk("out_ctrl", i, 64'(out_ctrl_w[i]), 64'(sb_ctrl[i][head[i]]));
          chk("out_data", i, 64'(out_data_w[i]), 64'(sb_data[i][head[i]]));
        end
        if (sz == 8'd0 && bubble[i]) chk("bubble_ctrl", i, 64'(out_ctrl_w[i]), 64'(BUB));
        if (sz == 8'd0 && zdata[i]) chk("reset_data", i, 64'(out_data_w[i]), 64'd0);
      end
      if (rst) begin
        head[i]      = tail[i];
        exp_stall[i] = 16'd0;
        bubble[i]    = 1'b1;
        zdata[i]     = 1'b1;
      end else begin
        if (ev && !out_ready && exp_stall[i] != 16'hFFFF) exp_stall[i] = exp_stall[i] + 16'd1;
        if (flush) begin
          head[i]   = tail[i];
          bubble[i] = 1'b1;
        end else if (ev && out_ready) begin
          head[i] = head[i] + 8'd1;
        end
      end
    end
    if (rst) armed = 1'b1;
  end

  // Driver: applies one cycle of stimulus and pushes whatever each DUT should accept.
  task automatic drive(input logic r, input logic e, input logic f, input logic k,
                       input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic o);
    @(posedge clk);
    #1;
    rst = r; en = e; flush = f; kill_ctrl = k; in_valid = v;
    in_ctrl = c; in_data = d; out_ready = o;
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (v && !f && exp_ready[i]) begin
        sb_ctrl[i][tail[i]] = k ? BUB : c;
        sb_data[i][tail[i]] = d;
        tail[i] = tail[i] + 8'd1;
      end
    end
  endtask

  task automatic idle(input logic o, input int n);
    for (int j = 0; j < n; j++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, o);
  endtask

  initial begin
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    // Stream with no backpressure.
    for (int j = 0; j < 3; j++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 32'h10 + j, 1'b1);
    idle(1'b1, 2);
    // Backpressure fills the skid buffer.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 32'hA0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 32'hA1, 1'b0);
    for (int j = 0; j < 3; j++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h04, 32'hA2, 1'b0);
    for (int j = 0; j < 2; j++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h04, 32'hA2, 1'b1);
    idle(1'b1, 3);
    // Flush while full with a beat offered.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h06, 32'hB0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07, 32'hB1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h05, 32'h99, 1'b0);
    idle(1'b1, 2);
    // Control kill, then kill together with flush.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 32'h8000_0040, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 2);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 32'h8000_0041, 1'b1);
    idle(1'b1, 2);
    // Global stall while holding a beat.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h08, 32'h33, 1'b0);
    for (int j = 0; j < 3; j++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h09, 32'h44, 1'b1);
    idle(1'b1, 2);
    // Randomized traffic.
    for (int j = 0; j < 3000; j++) begin
      logic e, f;
      e = ($urandom_range(99, 0) < 88);
      f = e && ($urandom_range(99, 0) < 3);
      drive(1'b0, e, f, ($urandom_range(99, 0) < 20), ($urandom_range(99, 0) < 70),
            CW'($urandom), DW'($urandom), ($urandom_range(99, 0) < 60));
    end
    idle(1'b1, 3);
    // Stall counter saturation, then reset clears it.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0A, 32'h55, 1'b0);
    idle(1'b0, 70000);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    idle(1'b1, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
